// File: rtl/result_bcd_display_pkg.sv
// Shared types and 7-segment constants for the result display path.
// Active-low segment order is {g,f,e,d,c,b,a}.
package calc_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ENCODE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Entry [n] is the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_DIGITS[digit];
    return seg;
  endfunction

endpackage

// File: rtl/result_bcd_display_if.sv
// Result handshake between the calculator datapath (master) and the
// BCD display stage (slave).
interface result_bcd_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_negative;
  logic       in_div_by_zero;

  modport master (
    output in_valid,
    output in_data,
    output in_negative,
    output in_div_by_zero,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_negative,
    input  in_div_by_zero,
    output in_ready
  );
endinterface

// File: rtl/result_bcd_display_seg7_encoder.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-decimal codes (10..15) decode to a blank digit.
module seg7_encoder
  import calc_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = digit_to_seg(digit);

endmodule

// File: rtl/result_bcd_display.sv
// Multi-cycle binary-to-BCD (double-dabble) converter driving three
// registered active-low 7-segment displays. Optional: LEADING_ZERO_BLANK_EN.
module result_bcd_display
  import calc_display_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  result_bcd_display_if.slave  bus,
  output logic [6:0]           seg_hundreds,
  output logic [6:0]           seg_tens,
  output logic [6:0]           seg_ones,
  output logic                 out_valid,
  output logic                 busy
);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        cnt_load;
  logic        seg_load;
  logic        xfer;

  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic        neg_q;
  logic        dbz_q;

  logic [6:0]  enc_h, enc_t, enc_o;
  logic [6:0]  nxt_h, nxt_t, nxt_o;

  function automatic logic [11:0] add3_nibbles(input logic [11:0] v);
    logic [11:0] r;
    logic [3:0]  nib;
    r = v;
    for (int i = 0; i < 3; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) r[4*i +: 4] = nib + 4'd3;
    end
    return r;
  endfunction

  assign xfer         = bus.in_valid && bus.in_ready;
  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign bcd_adj      = add3_nibbles(bcd_q);

  // Control: FSM state and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      if (cnt_load)
        cnt <= 3'd7;
      else if (state == SHIFT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    seg_load  = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          cnt_load  = 1'b1;
          state_nxt = bus.in_div_by_zero ? ENCODE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 3'd0) state_nxt = ENCODE;
      end
      ENCODE: begin
        seg_load  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture and shift-and-add-3; contents are don't-care in IDLE
  always_ff @(posedge clk) begin
    if (xfer) begin
      bin_q <= bus.in_data;
      bcd_q <= 12'd0;
      neg_q <= bus.in_negative;
      dbz_q <= bus.in_div_by_zero;
    end else if (state == SHIFT) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
    end
  end

  seg7_encoder u_enc_hundreds (.digit(bcd_q[11:8]), .seg(enc_h));
  seg7_encoder u_enc_tens     (.digit(bcd_q[7:4]),  .seg(enc_t));
  seg7_encoder u_enc_ones     (.digit(bcd_q[3:0]),  .seg(enc_o));

  always_comb begin
    nxt_h = enc_h;
    nxt_t = enc_t;
    nxt_o = enc_o;
    if (dbz_q) begin
      nxt_h = SEG_E;
      nxt_t = SEG_R;
      nxt_o = SEG_R;
    end else begin
      if (neg_q)
        nxt_h = SEG_MINUS;
`ifdef LEADING_ZERO_BLANK_EN
      else if (bcd_q[11:8] == 4'd0)
        nxt_h = SEG_BLANK;
      if (bcd_q[11:4] == 8'd0)
        nxt_t = SEG_BLANK;
`endif
    end
  end

  // Output stage: displays hold their value until the next ENCODE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_hundreds <= SEG_BLANK;
      seg_tens     <= SEG_BLANK;
      seg_ones     <= SEG_BLANK;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= seg_load;
      if (seg_load) begin
        seg_hundreds <= nxt_h;
        seg_tens     <= nxt_t;
        seg_ones     <= nxt_o;
      end
    end
  end

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: latency, digit patterns, error
// display, ignored mid-conversion input and asynchronous reset.
module tb_result_bcd_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_0     = 7'b1000000;
  localparam logic [6:0] P_1     = 7'b1111001;
  localparam logic [6:0] P_2     = 7'b0100100;
  localparam logic [6:0] P_3     = 7'b0110000;
  localparam logic [6:0] P_4     = 7'b0011001;
  localparam logic [6:0] P_5     = 7'b0010010;
  localparam logic [6:0] P_7     = 7'b1111000;
  localparam logic [6:0] P_9     = 7'b0010000;
  localparam logic [6:0] P_MINUS = 7'b0111111;
  localparam logic [6:0] P_E     = 7'b0000110;
  localparam logic [6:0] P_R     = 7'b0101111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg_hundreds, seg_tens, seg_ones;
  logic       out_valid, busy;
  int         total = 0;
  int         bad = 0;
  int         lat;
  int         pulses;

  always #5 clk = ~clk;

  result_bcd_display_if bus();

  result_bcd_display dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .seg_hundreds (seg_hundreds),
    .seg_tens     (seg_tens),
    .seg_ones     (seg_ones),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic neg, input logic dbz);
    bus.in_valid       = 1'b1;
    bus.in_data        = d;
    bus.in_negative    = neg;
    bus.in_div_by_zero = dbz;
    tick();
    bus.in_valid       = 1'b0;
    bus.in_data        = 8'd0;
    bus.in_negative    = 1'b0;
    bus.in_div_by_zero = 1'b0;
  endtask

  // Ticks until out_valid (bounded); busy/in_ready must hold while waiting.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (out_valid) break;
      check({tag, "_busy"}, {7'd0, busy}, 8'd1);
      check({tag, "_ready"}, {7'd0, bus.in_ready}, 8'd0);
    end
  endtask

  task automatic check_segs(input string tag, input logic [6:0] h,
                            input logic [6:0] t, input logic [6:0] o);
    check({tag, "_hex2"}, {1'b0, seg_hundreds}, {1'b0, h});
    check({tag, "_hex1"}, {1'b0, seg_tens},     {1'b0, t});
    check({tag, "_hex0"}, {1'b0, seg_ones},     {1'b0, o});
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_data        = 8'd0;
    bus.in_negative    = 1'b0;
    bus.in_div_by_zero = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check_segs("rst", P_BLANK, P_BLANK, P_BLANK);
    check("rst_ready", {7'd0, bus.in_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_ovld", {7'd0, out_valid}, 8'd0);
    reset = 1'b1;
    tick();

    // 0
    send(8'd0, 1'b0, 1'b0);
    check("d0_busy_t0", {7'd0, busy}, 8'd1);
    check("d0_ready_t0", {7'd0, bus.in_ready}, 8'd0);
    wait_out("d0", lat);
    check("d0_lat", lat[7:0], 8'd9);
    check_segs("d0", LZB ? P_BLANK : P_0, LZB ? P_BLANK : P_0, P_0);
    check("d0_ready_done", {7'd0, bus.in_ready}, 8'd1);
    tick();
    check("d0_ovld_drop", {7'd0, out_valid}, 8'd0);
    check("d0_hold", {1'b0, seg_ones}, {1'b0, P_0});

    // 255
    send(8'd255, 1'b0, 1'b0);
    wait_out("d255", lat);
    check("d255_lat", lat[7:0], 8'd9);
    check_segs("d255", P_2, P_5, P_5);
    tick();
    check("d255_ovld_drop", {7'd0, out_valid}, 8'd0);

    // -7
    send(8'd7, 1'b1, 1'b0);
    wait_out("neg7", lat);
    check("neg7_lat", lat[7:0], 8'd9);
    check_segs("neg7", P_MINUS, LZB ? P_BLANK : P_0, P_7);
    tick();

    // divide by zero: data ignored, 1-cycle latency
    send(8'd99, 1'b1, 1'b1);
    check("dbz_busy_t0", {7'd0, busy}, 8'd1);
    wait_out("dbz", lat);
    check("dbz_lat", lat[7:0], 8'd1);
    check_segs("dbz", P_E, P_R, P_R);
    tick();
    check("dbz_ovld_drop", {7'd0, out_valid}, 8'd0);
    check("dbz_ready", {7'd0, bus.in_ready}, 8'd1);

    // 42, with 13 offered at T4 while busy
    send(8'd42, 1'b0, 1'b0);
    repeat (3) tick();
    send(8'd13, 1'b0, 1'b0);
    wait_out("d42", lat);
    check("d42_lat_rest", lat[7:0], 8'd5);
    check_segs("d42", LZB ? P_BLANK : P_0, P_4, P_2);
    tick();

    // follow-up transfer after in_ready returns
    send(8'd13, 1'b0, 1'b0);
    wait_out("d13", lat);
    check("d13_lat", lat[7:0], 8'd9);
    check_segs("d13", LZB ? P_BLANK : P_0, P_1, P_3);
    tick();

    // 100: zero tens below a nonzero hundreds always shows
    send(8'd100, 1'b0, 1'b0);
    wait_out("d100", lat);
    check_segs("d100", P_1, P_0, P_0);
    tick();

    // reset in the middle of converting 200
    send(8'd200, 1'b0, 1'b0);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check_segs("mrst", P_BLANK, P_BLANK, P_BLANK);
    check("mrst_ready", {7'd0, bus.in_ready}, 8'd1);
    check("mrst_busy", {7'd0, busy}, 8'd0);
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("mrst_no_ovld", pulses[7:0], 8'd0);
    check("mrst_ready_after", {7'd0, bus.in_ready}, 8'd1);
    check_segs("mrst_after", P_BLANK, P_BLANK, P_BLANK);

    // recovery after reset
    send(8'd9, 1'b0, 1'b0);
    wait_out("d9", lat);
    check("d9_lat", lat[7:0], 8'd9);
    check_segs("d9", LZB ? P_BLANK : P_0, LZB ? P_BLANK : P_0, P_9);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
